rename_dispatch_stage: RTL and testbench
========================================

Name: rename_dispatch_stage

Overview:
- Parametrised decode/rename/dispatch stage between decode and NUM_RS reservation stations.
- Renames source operands through the map table, ROB and regfile, allocates a ROB entry, and updates the map table.
- Holds renamed instructions in a 2-entry skid buffer that snoops the CDB and wakes up operands.
- Dispatches the buffer head to one selected RS under per-RS ready backpressure.

Parameters:
ROB_SIZE, 32, ROB entries; tag 0 is reserved for "value ready".
TAG_W, $clog2(ROB_SIZE+1), ROB tag / map-table entry width.
NUM_RS, 4, number of reservation stations.
RS_SEL_W, $clog2(NUM_RS), RS select width.
CMD_W, 10, RS command bundle width.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
flush_i  in  1  discard all buffered and incoming instructions
in_valid_i / in_ready_o  in/out  1  decode handshake
rd_i, rn_i, rm_i  in  5 each  architectural registers
reg2loc_i  in  1  1: src2=rm_i, 0: src2=rd_i
reg_write_i, alu_src_i, is_branch_i  in  1 each  control bits
imm_i  in  64  pre-extended immediate
pc_i  in  64  instruction PC
cmd_i  in  CMD_W  RS command bundle
rs_sel_i  in  RS_SEL_W  target RS
map_raddr1_o, map_raddr2_o, map_waddr_o  out  5 each  map table addresses
map_rdata1_i, map_rdata2_i  in  TAG_W each  map table read data (combinational read)
map_wdata_o  out  TAG_W  map table write data
map_we_o  out  1  map table write enable
rob_raddr1_o, rob_raddr2_o  out  TAG_W each  ROB read addresses
rob_rdata1_i, rob_rdata2_i  in  65 each  ROB read data; bit64=done, [63:0]=value
rob_tail_i  in  TAG_W  next ROB tag
rob_full_i  in  1  ROB full
rob_alloc_o  out  1  ROB allocate
rob_alloc_data_o  out  8  {cmd type[2:0], rd}; cmd type = cmd_i[2:0]
rf_raddr1_o, rf_raddr2_o  out  5 each  regfile read addresses
rf_rdata1_i, rf_rdata2_i  in  64 each  regfile read data
cdb_valid_i, cdb_tag_i, cdb_data_i  in  1/TAG_W/64  result broadcast
disp_valid_o  out  NUM_RS  one-hot dispatch valid
rs_ready_i  in  NUM_RS  per-RS ready
disp_tag_o, disp_tag1_o, disp_tag2_o  out  TAG_W each  destination and source tags
disp_val1_o, disp_val2_o  out  64 each  operand values
disp_cmd_o  out  CMD_W  command bundle

Behaviour:
- Reset: count=0, all buffer entries invalid, disp_valid_o=0, map_we_o=0, rob_alloc_o=0, in_ready_o=0 while reset_i is high.
- in_ready_o = (count<2) & ~rob_full_i & ~flush_i & ~reset_i.
- accept = in_valid_i & in_ready_o.
- On accept, in the same cycle: rob_alloc_o=1; map_we_o = reg_write_i & (rd_i!=31); map_waddr_o=rd_i; map_wdata_o=rob_tail_i.
- Address outputs are driven unconditionally: map_raddr1_o/rf_raddr1_o=rn_i; map_raddr2_o/rf_raddr2_o=src2; rob_raddrN_o=map_rdataN_i.
- src1 rename:
  - map==0: tag1=0, val1=regfile value.
  - ROB done: tag1=0, val1=ROB value.
  - otherwise: tag1=map, val1=don't-care.
- src2 rename: is_branch_i gives val2=pc_i, tag2=0. Else alu_src_i gives val2=imm_i, tag2=0. Else renamed like src1.
- Same-cycle bypass: a renamed tag with tagN!=0 and cdb_valid_i & cdb_tag_i==tagN is captured as tagN=0, valN=cdb_data_i.
- Buffer snoop: every cycle, each valid entry with tagN!=0 matching the CDB clears tagN and captures valN.
- Dispatch:
  - Head drives the disp_* outputs; disp_valid_o[k] = head_valid & (head.rs_sel==k).
  - dequeue = head_valid & rs_ready_i[head.rs_sel].
  - The dispatched operands include any CDB capture made in the same cycle (combinational bypass on the head).
- count update:
  - accept only: +1.
  - dequeue only: −1.
  - accept and dequeue together: unchanged, full throughput at count 1.
  - count 2 with dequeue: in_ready_o stays 0 that cycle (registered count).
- Latency: accept cycle N → disp_valid_o at N+1 earliest.
- Flush: count→0 and entries invalid at the next edge; no accept, map_we_o=0 and rob_alloc_o=0 during the flush cycle.
- Reset mid-operation: buffer cleared immediately (asynchronous).
- rob_full_i=1 blocks accept without affecting dispatch.

Decomposition:
- Package rename_pkg:
  - disp_entry_t struct {tag, tag1, tag2, val1, val2, cmd, rs_sel}.
  - TAG_READY=0.
  - ZERO_REG=5'd31.
- Sub-module dispatch_skid_buffer: 2-entry FIFO with CDB snoop and head bypass.

Test Plan:
- Accept and dispatch:
  - Stimulus: reset; accept rd=3, rn=1 (map 0, rf 64'h10), rm=2 reg2loc=1 (map 5, ROB[5] not done), rob_tail=7, rs_sel=2, rs_ready=4'hF.
  - Same cycle: map_we_o=1, waddr=3, wdata=7.
  - Next cycle: disp_valid_o=4'b0100, tag=7, tag1=0, val1=0x10, tag2=5.
- Backpressure: rs_ready=0, 3 back-to-back valid instructions → 2 accepted; in_ready_o=0 from the 3rd cycle; map_we_o/rob_alloc_o pulse only twice; head held stable.
- Buffered wakeup: held entry tag2=5; cdb_valid=1, tag=5, data=64'hABCD → next cycle disp_tag2_o=0, disp_val2_o=64'hABCD.
- Accept-cycle bypass: renamed tag1=9 while cdb_tag=9, data=64'h55 → dispatched tag1=0, val1=64'h55.
- Flush: flush_i at count=2 with in_valid_i=1 → next cycle disp_valid_o=0, in_ready_o=1; map_we_o=0 during the flush cycle.
- XZR and ROB full:
  - rd=31, reg_write=1 → map_we_o=0, rob_alloc_o=1.
  - rob_full_i=1 → in_ready_o=0; head still dispatches.

Source files
------------

// File: rtl/rename_dispatch_stage_pkg.sv
// Shared types and constants for the rename/dispatch stage.
// Default widths live here so the packed dispatch entry has a single definition.
package rename_pkg;

  localparam int unsigned RobSize = 32;
  localparam int unsigned TagW    = $clog2(RobSize + 1);
  localparam int unsigned NumRs   = 4;
  localparam int unsigned RsSelW  = $clog2(NumRs);
  localparam int unsigned CmdW    = 10;

  localparam logic [TagW-1:0] TAG_READY = '0;
  localparam logic [4:0]      ZERO_REG  = 5'd31;

  typedef struct packed {
    logic [TagW-1:0]   tag;
    logic [TagW-1:0]   tag1;
    logic [TagW-1:0]   tag2;
    logic [63:0]       val1;
    logic [63:0]       val2;
    logic [CmdW-1:0]   cmd;
    logic [RsSelW-1:0] rs_sel;
  } disp_entry_t;

  typedef struct packed {
    logic [TagW-1:0] tag;
    logic [63:0]     val;
  } operand_t;

  // Wake up any pending operand whose producer is on the CDB this cycle.
  function automatic disp_entry_t cdb_snoop(input disp_entry_t     e,
                                            input logic            cdb_valid,
                                            input logic [TagW-1:0] cdb_tag,
                                            input logic [63:0]     cdb_data);
    disp_entry_t r;
    r = e;
    if (cdb_valid && (e.tag1 != TAG_READY) && (e.tag1 == cdb_tag)) begin
      r.tag1 = TAG_READY;
      r.val1 = cdb_data;
    end
    if (cdb_valid && (e.tag2 != TAG_READY) && (e.tag2 == cdb_tag)) begin
      r.tag2 = TAG_READY;
      r.val2 = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/rename_dispatch_stage_if.sv
// Bundle of decode, map-table, ROB, regfile, CDB and RS-dispatch signals.
// master: the rename/dispatch stage; slave: the surrounding pipeline.
interface rename_dispatch_stage_if
  import rename_pkg::*;
#(
  parameter int unsigned TAG_W    = TagW,
  parameter int unsigned NUM_RS   = NumRs,
  parameter int unsigned RS_SEL_W = RsSelW,
  parameter int unsigned CMD_W    = CmdW
);

  logic                flush_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [4:0]          rd_i;
  logic [4:0]          rn_i;
  logic [4:0]          rm_i;
  logic                reg2loc_i;
  logic                reg_write_i;
  logic                alu_src_i;
  logic                is_branch_i;
  logic [63:0]         imm_i;
  logic [63:0]         pc_i;
  logic [CMD_W-1:0]    cmd_i;
  logic [RS_SEL_W-1:0] rs_sel_i;

  logic [4:0]          map_raddr1_o;
  logic [4:0]          map_raddr2_o;
  logic [4:0]          map_waddr_o;
  logic [TAG_W-1:0]    map_rdata1_i;
  logic [TAG_W-1:0]    map_rdata2_i;
  logic [TAG_W-1:0]    map_wdata_o;
  logic                map_we_o;

  logic [TAG_W-1:0]    rob_raddr1_o;
  logic [TAG_W-1:0]    rob_raddr2_o;
  logic [64:0]         rob_rdata1_i;
  logic [64:0]         rob_rdata2_i;
  logic [TAG_W-1:0]    rob_tail_i;
  logic                rob_full_i;
  logic                rob_alloc_o;
  logic [7:0]          rob_alloc_data_o;

  logic [4:0]          rf_raddr1_o;
  logic [4:0]          rf_raddr2_o;
  logic [63:0]         rf_rdata1_i;
  logic [63:0]         rf_rdata2_i;

  logic                cdb_valid_i;
  logic [TAG_W-1:0]    cdb_tag_i;
  logic [63:0]         cdb_data_i;

  logic [NUM_RS-1:0]   disp_valid_o;
  logic [NUM_RS-1:0]   rs_ready_i;
  logic [TAG_W-1:0]    disp_tag_o;
  logic [TAG_W-1:0]    disp_tag1_o;
  logic [TAG_W-1:0]    disp_tag2_o;
  logic [63:0]         disp_val1_o;
  logic [63:0]         disp_val2_o;
  logic [CMD_W-1:0]    disp_cmd_o;

  modport master (
    input  flush_i, in_valid_i, rd_i, rn_i, rm_i, reg2loc_i, reg_write_i, alu_src_i,
           is_branch_i, imm_i, pc_i, cmd_i, rs_sel_i,
           map_rdata1_i, map_rdata2_i, rob_rdata1_i, rob_rdata2_i, rob_tail_i, rob_full_i,
           rf_rdata1_i, rf_rdata2_i, cdb_valid_i, cdb_tag_i, cdb_data_i, rs_ready_i,
    output in_ready_o, map_raddr1_o, map_raddr2_o, map_waddr_o, map_wdata_o, map_we_o,
           rob_raddr1_o, rob_raddr2_o, rob_alloc_o, rob_alloc_data_o,
           rf_raddr1_o, rf_raddr2_o,
           disp_valid_o, disp_tag_o, disp_tag1_o, disp_tag2_o, disp_val1_o, disp_val2_o,
           disp_cmd_o
  );

  modport slave (
    output flush_i, in_valid_i, rd_i, rn_i, rm_i, reg2loc_i, reg_write_i, alu_src_i,
           is_branch_i, imm_i, pc_i, cmd_i, rs_sel_i,
           map_rdata1_i, map_rdata2_i, rob_rdata1_i, rob_rdata2_i, rob_tail_i, rob_full_i,
           rf_rdata1_i, rf_rdata2_i, cdb_valid_i, cdb_tag_i, cdb_data_i, rs_ready_i,
    input  in_ready_o, map_raddr1_o, map_raddr2_o, map_waddr_o, map_wdata_o, map_we_o,
           rob_raddr1_o, rob_raddr2_o, rob_alloc_o, rob_alloc_data_o,
           rf_raddr1_o, rf_raddr2_o,
           disp_valid_o, disp_tag_o, disp_tag1_o, disp_tag2_o, disp_val1_o, disp_val2_o,
           disp_cmd_o
  );

endinterface

// File: rtl/dispatch_skid_buffer.sv
// Two-entry in-order buffer of renamed instructions. Entries snoop the CDB every
// cycle and the head is presented with that cycle's CDB capture already applied.
module dispatch_skid_buffer
  import rename_pkg::*;
#(
  parameter int unsigned TAG_W  = TagW,
  parameter int unsigned NUM_RS = NumRs
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  disp_entry_t       push_entry_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [63:0]       cdb_data_i,
  input  logic [NUM_RS-1:0] rs_ready_i,
  output logic [1:0]        count_o,
  output logic              head_valid_o,
  output disp_entry_t       head_o
);

  disp_entry_t entry_q [2];
  disp_entry_t entry_d [2];
  disp_entry_t snooped [2];
  logic [1:0]  count_q, count_d;
  logic        head_valid;
  logic        pop;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      snooped[i] = cdb_snoop(entry_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
    end
    head_valid = (count_q != 2'd0);
    pop        = head_valid & rs_ready_i[entry_q[0].rs_sel];

    entry_d[0] = snooped[0];
    entry_d[1] = snooped[1];
    count_d    = count_q;

    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        entry_d[0] = snooped[1];
      end
      // Slot 0 is free when empty or when the head leaves this cycle.
      if (push_i) begin
        if ((count_q == 2'd0) || pop) begin
          entry_d[0] = push_entry_i;
        end else begin
          entry_d[1] = push_entry_i;
        end
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q    <= 2'd0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      count_q    <= count_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = head_valid;
  assign head_o       = snooped[0];

endmodule

// File: rtl/rename_dispatch_stage.sv
// Decode-side rename: resolves source operands via map table, ROB and regfile,
// allocates a ROB entry, updates the map table and feeds the dispatch skid buffer.
module rename_dispatch_stage
  import rename_pkg::*;
#(
  parameter int unsigned ROB_SIZE = RobSize,
  parameter int unsigned TAG_W    = $clog2(ROB_SIZE + 1),
  parameter int unsigned NUM_RS   = NumRs,
  parameter int unsigned RS_SEL_W = $clog2(NUM_RS),
  parameter int unsigned CMD_W    = CmdW
) (
  input logic                     clk_i,
  input logic                     reset_i,
  rename_dispatch_stage_if.master bus_io
);

  logic [1:0]        count;
  logic              head_valid;
  disp_entry_t       head;
  disp_entry_t       push_entry;
  logic              in_ready;
  logic              accept;
  logic [4:0]        src2;
  operand_t          op1, op2;
  logic [NUM_RS-1:0] disp_valid;

  function automatic operand_t rename_src(input logic [TAG_W-1:0] map,
                                          input logic [64:0]      rob,
                                          input logic [63:0]      rf);
    operand_t o;
    if (map == TAG_READY) begin
      o.tag = TAG_READY;
      o.val = rf;
    end else if (rob[64]) begin
      o.tag = TAG_READY;
      o.val = rob[63:0];
    end else begin
      o.tag = map;
      o.val = '0;
    end
    return o;
  endfunction

  assign in_ready = (count < 2'd2) & ~bus_io.rob_full_i & ~bus_io.flush_i & ~reset_i;
  assign accept   = bus_io.in_valid_i & in_ready;
  assign src2     = bus_io.reg2loc_i ? bus_io.rm_i : bus_io.rd_i;

  always_comb begin
    op1 = rename_src(bus_io.map_rdata1_i, bus_io.rob_rdata1_i, bus_io.rf_rdata1_i);
    if (bus_io.is_branch_i) begin
      op2.tag = TAG_READY;
      op2.val = bus_io.pc_i;
    end else if (bus_io.alu_src_i) begin
      op2.tag = TAG_READY;
      op2.val = bus_io.imm_i;
    end else begin
      op2 = rename_src(bus_io.map_rdata2_i, bus_io.rob_rdata2_i, bus_io.rf_rdata2_i);
    end

    push_entry.tag    = bus_io.rob_tail_i;
    push_entry.tag1   = op1.tag;
    push_entry.tag2   = op2.tag;
    push_entry.val1   = op1.val;
    push_entry.val2   = op2.val;
    push_entry.cmd    = bus_io.cmd_i;
    push_entry.rs_sel = bus_io.rs_sel_i;
    // A producer broadcasting in the rename cycle would otherwise be missed.
    push_entry = cdb_snoop(push_entry, bus_io.cdb_valid_i, bus_io.cdb_tag_i, bus_io.cdb_data_i);
  end

  dispatch_skid_buffer #(
    .TAG_W  (TAG_W),
    .NUM_RS (NUM_RS)
  ) u_skid (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (bus_io.flush_i),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .cdb_valid_i  (bus_io.cdb_valid_i),
    .cdb_tag_i    (bus_io.cdb_tag_i),
    .cdb_data_i   (bus_io.cdb_data_i),
    .rs_ready_i   (bus_io.rs_ready_i),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  always_comb begin
    disp_valid = '0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      disp_valid[k] = head_valid & (head.rs_sel == RS_SEL_W'(k));
    end
  end

  assign bus_io.in_ready_o       = in_ready;
  assign bus_io.map_raddr1_o     = bus_io.rn_i;
  assign bus_io.map_raddr2_o     = src2;
  assign bus_io.rf_raddr1_o      = bus_io.rn_i;
  assign bus_io.rf_raddr2_o      = src2;
  assign bus_io.rob_raddr1_o     = bus_io.map_rdata1_i;
  assign bus_io.rob_raddr2_o     = bus_io.map_rdata2_i;
  assign bus_io.map_waddr_o      = bus_io.rd_i;
  assign bus_io.map_wdata_o      = bus_io.rob_tail_i;
  assign bus_io.map_we_o         = accept & bus_io.reg_write_i & (bus_io.rd_i != ZERO_REG);
  assign bus_io.rob_alloc_o      = accept;
  assign bus_io.rob_alloc_data_o = {bus_io.cmd_i[2:0], bus_io.rd_i};

  assign bus_io.disp_valid_o = disp_valid;
  assign bus_io.disp_tag_o   = head.tag;
  assign bus_io.disp_tag1_o  = head.tag1;
  assign bus_io.disp_tag2_o  = head.tag2;
  assign bus_io.disp_val1_o  = head.val1;
  assign bus_io.disp_val2_o  = head.val2;
  assign bus_io.disp_cmd_o   = head.cmd;

endmodule

// File: tb/tb_rename_dispatch_stage.sv
// Directed bench for rename_dispatch_stage: an expected-dispatch queue is filled as
// instructions are accepted and drained as the stage dispatches them.
module tb_rename_dispatch_stage;
  import rename_pkg::*;

  localparam int unsigned TW = TagW;
  localparam int unsigned CW = CmdW;

  typedef struct packed {
    logic [3:0]    rs;
    logic [TW-1:0] tag;
    logic [TW-1:0] tag1;
    logic [TW-1:0] tag2;
    logic [63:0]   val1;
    logic [63:0]   val2;
    logic [CW-1:0] cmd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [TW-1:0] map_tb [32];
  logic [64:0]   rob_tb [64];
  logic [63:0]   rf_tb  [32];

  rename_dispatch_stage_if bus ();

  rename_dispatch_stage dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  assign bus.map_rdata1_i = map_tb[bus.map_raddr1_o];
  assign bus.map_rdata2_i = map_tb[bus.map_raddr2_o];
  assign bus.rob_rdata1_i = rob_tb[bus.rob_raddr1_o];
  assign bus.rob_rdata2_i = rob_tb[bus.rob_raddr2_o];
  assign bus.rf_rdata1_i  = rf_tb[bus.rf_raddr1_o];
  assign bus.rf_rdata2_i  = rf_tb[bus.rf_raddr2_o];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive_instr(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                             input logic reg2loc, input logic reg_write, input logic alu_src,
                             input logic is_branch, input logic [63:0] imm,
                             input logic [63:0] pc, input logic [CW-1:0] cmd,
                             input logic [1:0] rs_sel, input logic [TW-1:0] tail);
    bus.in_valid_i  = 1'b1;
    bus.rd_i        = rd;
    bus.rn_i        = rn;
    bus.rm_i        = rm;
    bus.reg2loc_i   = reg2loc;
    bus.reg_write_i = reg_write;
    bus.alu_src_i   = alu_src;
    bus.is_branch_i = is_branch;
    bus.imm_i       = imm;
    bus.pc_i        = pc;
    bus.cmd_i       = cmd;
    bus.rs_sel_i    = rs_sel;
    bus.rob_tail_i  = tail;
  endtask

  task automatic expect_dispatch(input string name);
    exp_t e;
    n_checks++;
    assert (sb.size() != 0)
    else begin
      n_fail++;
      $error("FAIL %s: observed dispatch %h expected empty scoreboard", name, bus.disp_valid_o);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({name, ".valid"}, 64'(bus.disp_valid_o), 64'(e.rs));
      check({name, ".tag"},   64'(bus.disp_tag_o),   64'(e.tag));
      check({name, ".tag1"},  64'(bus.disp_tag1_o),  64'(e.tag1));
      check({name, ".tag2"},  64'(bus.disp_tag2_o),  64'(e.tag2));
      check({name, ".cmd"},   64'(bus.disp_cmd_o),   64'(e.cmd));
      if (e.tag1 == TAG_READY) check({name, ".val1"}, bus.disp_val1_o, e.val1);
      if (e.tag2 == TAG_READY) check({name, ".val2"}, bus.disp_val2_o, e.val2);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      map_tb[i] = '0;
      rf_tb[i]  = 64'(i) * 64'd16;
    end
    for (int i = 0; i < 64; i++) rob_tb[i] = '0;
    map_tb[2]  = TW'(5);
    map_tb[12] = TW'(9);
    map_tb[14] = TW'(20);
    rob_tb[20] = {1'b1, 64'hBEEF};

    reset           = 1'b1;
    bus.flush_i     = 1'b0;
    bus.rob_full_i  = 1'b0;
    bus.cdb_valid_i = 1'b0;
    bus.cdb_tag_i   = '0;
    bus.cdb_data_i  = '0;
    bus.rs_ready_i  = 4'hF;
    drive_instr(5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 10'h045, 2'd2, TW'(7));

    // Reset holds everything idle even with a valid instruction presented.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready",  64'(bus.in_ready_o),   0);
    check("rst.disp",      64'(bus.disp_valid_o), 0);
    check("rst.map_we",    64'(bus.map_we_o),     0);
    check("rst.rob_alloc", 64'(bus.rob_alloc_o),  0);
    step();
    reset          = 1'b0;
    bus.in_valid_i = 1'b0;

    // Accept and dispatch.
    step();
    drive_instr(5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 10'h045, 2'd2, TW'(7));
    sb.push_back('{rs: 4'b0100, tag: TW'(7), tag1: TW'(0), tag2: TW'(5),
                   val1: 64'h10, val2: 64'h0, cmd: 10'h045});
    @(negedge clk);
    check("acc.in_ready",   64'(bus.in_ready_o),       1);
    check("acc.map_we",     64'(bus.map_we_o),         1);
    check("acc.waddr",      64'(bus.map_waddr_o),      3);
    check("acc.wdata",      64'(bus.map_wdata_o),      7);
    check("acc.rob_alloc",  64'(bus.rob_alloc_o),      1);
    check("acc.alloc_data", 64'(bus.rob_alloc_data_o), 64'hA3);
    check("acc.raddr2",     64'(bus.map_raddr2_o),     2);
    check("acc.rob_raddr2", 64'(bus.rob_raddr2_o),     5);
    check("acc.latency",    64'(bus.disp_valid_o),     0);
    step();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    expect_dispatch("accept");

    // Backpressure: three back-to-back instructions, only two fit.
    step();
    bus.rs_ready_i = 4'h0;
    drive_instr(5'd4, 5'd6, 5'd2, 1, 1, 0, 0, 0, 0, 10'h101, 2'd1, TW'(8));
    sb.push_back('{rs: 4'b0010, tag: TW'(8), tag1: TW'(0), tag2: TW'(5),
                   val1: 64'h60, val2: 64'h0, cmd: 10'h101});
    @(negedge clk);
    check("bp1.in_ready", 64'(bus.in_ready_o), 1);
    check("bp1.map_we",   64'(bus.map_we_o),   1);
    step();
    drive_instr(5'd10, 5'd7, 5'd0, 0, 1, 1, 0, 64'h1234, 0, 10'h0A2, 2'd0, TW'(9));
    sb.push_back('{rs: 4'b0001, tag: TW'(9), tag1: TW'(0), tag2: TW'(0),
                   val1: 64'h70, val2: 64'h1234, cmd: 10'h0A2});
    @(negedge clk);
    check("bp2.in_ready",  64'(bus.in_ready_o),   1);
    check("bp2.rob_alloc", 64'(bus.rob_alloc_o),  1);
    check("bp2.disp",      64'(bus.disp_valid_o), 4'b0010);
    check("bp2.tag",       64'(bus.disp_tag_o),   8);
    step();
    drive_instr(5'd13, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 10'h0, 2'd0, TW'(10));
    @(negedge clk);
    check("bp3.in_ready",  64'(bus.in_ready_o),   0);
    check("bp3.map_we",    64'(bus.map_we_o),     0);
    check("bp3.rob_alloc", 64'(bus.rob_alloc_o),  0);
    check("bp3.disp",      64'(bus.disp_valid_o), 4'b0010);
    check("bp3.tag",       64'(bus.disp_tag_o),   8);
    step();
    @(negedge clk);
    check("bp4.in_ready",  64'(bus.in_ready_o),  0);
    check("bp4.rob_alloc", 64'(bus.rob_alloc_o), 0);
    check("bp4.tag",       64'(bus.disp_tag_o),  8);

    // Buffered wakeup of the held head's src2.
    step();
    bus.in_valid_i  = 1'b0;
    bus.cdb_valid_i = 1'b1;
    bus.cdb_tag_i   = TW'(5);
    bus.cdb_data_i  = 64'hABCD;
    rob_tb[5]       = {1'b1, 64'hABCD};
    @(negedge clk);
    check("wk0.tag2", 64'(bus.disp_tag2_o), 0);
    step();
    bus.cdb_valid_i = 1'b0;
    @(negedge clk);
    check("wk1.tag2", 64'(bus.disp_tag2_o), 0);
    check("wk1.val2", bus.disp_val2_o, 64'hABCD);
    e      = sb.pop_front();
    e.tag2 = TAG_READY;
    e.val2 = 64'hABCD;
    sb.push_front(e);
    step();
    bus.rs_ready_i = 4'h2;
    @(negedge clk);
    expect_dispatch("wakeup");
    step();
    bus.rs_ready_i = 4'hF;
    @(negedge clk);
    expect_dispatch("alu_imm");

    // Rename-cycle CDB bypass on src1.
    step();
    drive_instr(5'd11, 5'd12, 5'd0, 0, 1, 0, 0, 0, 0, 10'h3FF, 2'd3, TW'(12));
    bus.cdb_valid_i = 1'b1;
    bus.cdb_tag_i   = TW'(9);
    bus.cdb_data_i  = 64'h55;
    sb.push_back('{rs: 4'b1000, tag: TW'(12), tag1: TW'(0), tag2: TW'(0),
                   val1: 64'h55, val2: 64'hB0, cmd: 10'h3FF});
    step();
    bus.in_valid_i  = 1'b0;
    bus.cdb_valid_i = 1'b0;
    @(negedge clk);
    expect_dispatch("bypass");

    // Flush with a full buffer and a valid instruction presented.
    step();
    bus.rs_ready_i = 4'h0;
    drive_instr(5'd1, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 10'h001, 2'd0, TW'(13));
    step();
    drive_instr(5'd2, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 10'h002, 2'd1, TW'(14));
    step();
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("fl.in_ready",  64'(bus.in_ready_o),   0);
    check("fl.map_we",    64'(bus.map_we_o),     0);
    check("fl.rob_alloc", 64'(bus.rob_alloc_o),  0);
    check("fl.disp",      64'(bus.disp_valid_o), 4'b0001);
    step();
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("fl2.disp",     64'(bus.disp_valid_o), 0);
    check("fl2.in_ready", 64'(bus.in_ready_o),   1);

    // XZR destination, branch src2 and ROB-done src1.
    step();
    bus.rs_ready_i = 4'hF;
    drive_instr(5'd31, 5'd14, 5'd0, 0, 1, 0, 1, 0, 64'h4000, 10'h007, 2'd0, TW'(15));
    sb.push_back('{rs: 4'b0001, tag: TW'(15), tag1: TW'(0), tag2: TW'(0),
                   val1: 64'hBEEF, val2: 64'h4000, cmd: 10'h007});
    @(negedge clk);
    check("xzr.map_we",     64'(bus.map_we_o),         0);
    check("xzr.rob_alloc",  64'(bus.rob_alloc_o),      1);
    check("xzr.alloc_data", 64'(bus.rob_alloc_data_o), 64'hFF);
    check("xzr.in_ready",   64'(bus.in_ready_o),       1);

    // ROB full blocks accept but not dispatch.
    step();
    bus.rob_full_i = 1'b1;
    drive_instr(5'd6, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 10'h0, 2'd0, TW'(16));
    @(negedge clk);
    check("full.in_ready",  64'(bus.in_ready_o),  0);
    check("full.rob_alloc", 64'(bus.rob_alloc_o), 0);
    expect_dispatch("rob_full");

    // Asynchronous reset while an entry is held.
    step();
    bus.rob_full_i = 1'b0;
    bus.rs_ready_i = 4'h0;
    drive_instr(5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 10'h0, 2'd2, TW'(16));
    @(negedge clk);
    check("ar.in_ready", 64'(bus.in_ready_o), 1);
    check("ar.map_we",   64'(bus.map_we_o),   0);
    step();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("ar.held", 64'(bus.disp_valid_o), 4'b0100);
    check("ar.tag",  64'(bus.disp_tag_o),   16);
    #2;
    reset = 1'b1;
    #1;
    check("ar.disp",     64'(bus.disp_valid_o), 0);
    check("ar.in_ready", 64'(bus.in_ready_o),   0);
    sb.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
